// File: rtl/util_tx_burst_scheduler_if.sv
// Handshake bundle for util_tx_burst_scheduler.
//   cmd_*    : host command channel (start time, block count)
//   s_axis_* : upstream sample blocks from the timestamped unpack FIFO
//   m_axis_* : sample blocks towards the DAC
// modport slave  : the scheduler's view
// modport master : the surrounding system's view (host, upstream source, DAC sink)
interface util_tx_burst_scheduler_if #(
  parameter int DATA_WIDTH = 64
) ();
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [63:0]           cmd_time;
  logic [31:0]           cmd_blocks;

  logic                  s_axis_valid;
  logic                  s_axis_ready;
  logic [DATA_WIDTH-1:0] s_axis_data;

  logic                  m_axis_valid;
  logic                  m_axis_ready;
  logic [DATA_WIDTH-1:0] m_axis_data;

  modport slave (
    input  cmd_valid, cmd_time, cmd_blocks,
    output cmd_ready,
    input  s_axis_valid, s_axis_data,
    output s_axis_ready,
    output m_axis_valid, m_axis_data,
    input  m_axis_ready
  );

  modport master (
    output cmd_valid, cmd_time, cmd_blocks,
    input  cmd_ready,
    output s_axis_valid, s_axis_data,
    input  s_axis_ready,
    input  m_axis_valid, m_axis_data,
    output m_axis_ready
  );
endinterface

// File: rtl/util_tx_burst_scheduler.sv
// Timed transmit burst scheduler, DAC clock domain.
// Holds the upstream sample stream until the DAC timestamp reaches a queued
// command's start time, then passes exactly that command's block count.
// Commands already past their start time are dropped and counted.
// Ports:
//   dac_clk, reset   : sole clock, asynchronous active-high reset
//   timestamp        : free-running DAC sample time
//   enable           : 0 flushes the queue and aborts any burst
//   cnt_clr          : synchronous clear of both event counters
//   bus              : command / upstream / downstream handshakes (slave modport)
//   busy             : FSM active or commands queued
//   cmd_level        : number of queued commands
//   late_count       : saturating count of dropped late commands
//   underflow_count  : saturating count of RUN cycles with ready and no valid
module util_tx_burst_scheduler #(
  parameter int DATA_WIDTH     = 64,
  parameter int CMD_DEPTH      = 4,
  parameter int LATE_TOLERANCE = 0
) (
  input  logic                       dac_clk,
  input  logic                       reset,
  input  logic [63:0]                timestamp,
  input  logic                       enable,
  input  logic                       cnt_clr,
  util_tx_burst_scheduler_if.slave   bus,
  output logic                       busy,
  output logic [$clog2(CMD_DEPTH):0] cmd_level,
  output logic [15:0]                late_count,
  output logic [15:0]                underflow_count
);

  localparam int          PTR_W    = $clog2(CMD_DEPTH);
  localparam int          LVL_W    = PTR_W + 1;
  localparam logic [63:0] LATE_TOL = 64'(LATE_TOLERANCE);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [63:0]      active_time_q, active_time_d;
  logic [31:0]      remaining_q, remaining_d;
  logic [15:0]      late_cnt_q, late_cnt_d;
  logic [15:0]      uf_cnt_q, uf_cnt_d;

  logic [63:0]      time_mem   [CMD_DEPTH];
  logic [31:0]      blocks_mem [CMD_DEPTH];

  logic                  full, empty, push, pop, run, beat, underflow_ev;
  logic                  ts_reached, is_late, late_inc;
  logic [63:0]           ts_diff;
  logic [DATA_WIDTH-1:0] pass_data;

  // cmd_ready looks only at registered fullness, so a pop in the same cycle
  // never opens a slot for a push until the next cycle.
  assign full  = (level_q == LVL_W'(CMD_DEPTH));
  assign empty = (level_q == '0);
  assign run   = (state_q == ST_RUN);

  assign bus.cmd_ready = !reset && enable && !full;
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign pop           = enable && (state_q == ST_IDLE) && !empty;

  // Zero-latency pass-through during RUN; upstream is back-pressured otherwise.
  assign pass_data        = bus.s_axis_data;
  assign bus.m_axis_valid = run && bus.s_axis_valid;
  assign bus.s_axis_ready = run && bus.m_axis_ready;
  assign bus.m_axis_data  = run ? pass_data : '0;

  assign beat         = run && bus.s_axis_valid && bus.m_axis_ready;
  assign underflow_ev = run && bus.m_axis_ready && !bus.s_axis_valid;

  // The difference is only meaningful once the start time has been reached.
  assign ts_reached = (timestamp >= active_time_q);
  assign ts_diff    = timestamp - active_time_q;
  assign is_late    = ts_reached && (ts_diff > LATE_TOL);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    state_d       = state_q;
    active_time_d = active_time_q;
    remaining_d   = remaining_q;
    late_inc      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A zero-block command is popped and discarded without touching late_count.
        if (pop && (blocks_mem[rd_ptr_q] != 32'd0)) begin
          active_time_d = time_mem[rd_ptr_q];
          remaining_d   = blocks_mem[rd_ptr_q];
          state_d       = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ts_reached) begin
          if (is_late) begin
            late_inc = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d  = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (beat) begin
          remaining_d = remaining_q - 32'd1;
          if (remaining_q == 32'd1) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Disabling still lets this cycle's handshake complete, then truncates.
    if (!enable) begin
      state_d  = ST_IDLE;
      late_inc = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (!enable) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_comb begin
    late_cnt_d = late_cnt_q;
    uf_cnt_d   = uf_cnt_q;
    if (late_inc && (late_cnt_q != 16'hFFFF)) late_cnt_d = late_cnt_q + 16'd1;
    if (underflow_ev && (uf_cnt_q != 16'hFFFF)) uf_cnt_d = uf_cnt_q + 16'd1;
    if (cnt_clr) begin
      late_cnt_d = '0;
      uf_cnt_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge dac_clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      active_time_q <= '0;
      remaining_q   <= '0;
      late_cnt_q    <= '0;
      uf_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      active_time_q <= active_time_d;
      remaining_q   <= remaining_d;
      late_cnt_q    <= late_cnt_d;
      uf_cnt_q      <= uf_cnt_d;
    end
  end

  // NOTE: queue storage is not reset; the level and pointers alone decide which entries are valid.
  always_ff @(posedge dac_clk) begin
    if (push) begin
      time_mem[wr_ptr_q]   <= bus.cmd_time;
      blocks_mem[wr_ptr_q] <= bus.cmd_blocks;
    end
  end

  assign busy            = (state_q != ST_IDLE) || !empty;
  assign cmd_level       = level_q;
  assign late_count      = late_cnt_q;
  assign underflow_count = uf_cnt_q;

endmodule
